uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin transmit scheduler that shares one `uart_core` transmitter among `NREQ` byte producers. It accepts bytes over per-requester valid/ready handshakes and honours the peer's flow-control line. It drives `txdata` with a one-cycle strobe per byte and paces bytes so a new byte is never presented while the previous frame is still on the wire. It sits between the requester logic and the `txdata`/`cts` side of a `uart_core` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `BIT_CLK`, 8: `clk` cycles per serial bit; must match the `uart_core` instance.
- `FRAME_BITS`, 10: bits per frame (start + 8 data + stop).
- `GAP_CLKS`, 0: extra idle `clk` cycles inserted after each frame.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `req_valid`  in  NREQ: bit i high means requester i offers `req_data[8*i+7:8*i]`.
- `req_data`  in  8*NREQ: packed request bytes.
- `req_ready`  out  NREQ: one-hot; byte i is accepted in a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `cts`  in  1: peer may accept data (1) or is stalled (0).
- `txdata`  out  8: byte presented to `uart_core`; holds its value between strobes.
- `tx_strobe`  out  1: one-cycle pulse when `txdata` takes a new byte.
- `busy`  out  1: high in SEND and GAP.
- `grant_id`  out  3: index of the requester whose byte is currently or was last sent.
- `sent_count`  out  16: bytes sent since reset; wraps 0xFFFF to 0x0000.

## Operation
- FSM states: IDLE, SEND, GAP. FRAME_CLKS = FRAME_BITS*BIT_CLK, computed at elaboration. The down-counter is wide enough for max(FRAME_CLKS, GAP_CLKS).
- **IDLE**
  - If `cts`=1 and any `req_valid` is set, `req_ready` is combinationally one-hot on the first valid requester at or after `rr_ptr`, searching upward with wrap.
  - In all other IDLE cycles, and in every other state, `req_ready` is all zeros.
  - On the accept cycle the block registers:
    - the byte into `txdata`;
    - `tx_strobe`=1 for the next cycle;
    - `grant_id` = winner;
    - `rr_ptr` = (winner+1) mod NREQ;
    - `sent_count` incremented;
    - next state SEND, counter = FRAME_CLKS-1.
- **SEND** decrements the counter each cycle. At 0 it goes to GAP with counter GAP_CLKS-1, or to IDLE if GAP_CLKS=0.
- **GAP** decrements the counter. At 0 it goes to IDLE.
- `cts` is sampled only in IDLE. A `cts` fall during SEND or GAP does not abort the frame; the block waits in IDLE until `cts`=1.
- A requester dropping `req_valid` before it is accepted loses nothing. Arbitration is re-evaluated every IDLE cycle.
- Requesters with `req_valid`=0 are skipped with no cycle penalty.

## Timing
- Reset values: `txdata`=0x00, `tx_strobe`=0, `busy`=0, `grant_id`=0, `sent_count`=0, `req_ready`=0, `rr_ptr`=0, state IDLE.
- Reset mid-frame takes effect on the next edge: the frame is abandoned and no strobe is issued.
- Latency: accept at cycle H gives `tx_strobe`=1 and the new `txdata` at H+1. `busy` is high for H+1 .. H+FRAME_CLKS+GAP_CLKS.
- The earliest next accept is H+FRAME_CLKS+GAP_CLKS+1. Minimum strobe spacing is FRAME_CLKS+GAP_CLKS+1 cycles (81 at the defaults).
- `rst` and a valid request in the same cycle: reset wins, nothing is accepted.
- `rr_ptr` wraps from NREQ-1 to 0.

## Test plan
- **Reset, then single byte.** Apply `rst` for 3 cycles. Requester 0 offers 0x77 with `cts`=1.
  - `req_ready`=0001 on the first IDLE cycle.
  - Next cycle: `tx_strobe`=1, `txdata`=0x77.
  - `busy` high for exactly 80 cycles.
  - `sent_count`=1.
- **All four requesters valid continuously** with bytes 0xA0..0xA3.
  - Grant order 0,1,2,3,0.
  - Strobes exactly 81 cycles apart.
  - `txdata` sequence A0, A1, A2, A3, A0.
- **Sparse requesters.** Only requesters 1 and 3 valid, with `rr_ptr`=2.
  - Grants alternate 3,1,3.
  - No idle cycles are spent on invalid requesters.
- **Flow control.** Drop `cts` mid-SEND and hold it low for 200 cycles with requester 2 valid.
  - The current frame completes.
  - `req_ready` stays 0 while `cts`=0.
  - Accept occurs on the first IDLE cycle with `cts`=1.
- **Gap and reset abort.** Set GAP_CLKS=5 and confirm strobe spacing is 86 cycles. Then assert `rst` 20 cycles into SEND.
  - All outputs return to their reset values the next cycle.
  - No strobe is issued.
- **Counter wrap.** Preload `sent_count` to 0xFFFF (force) and send one byte. Require 0x0000.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler. Several byte producers share one uart_core
// transmitter. Bytes are accepted over valid/ready handshakes, then paced so
// that a new byte is only presented once the previous frame (plus an optional
// idle gap) has left the wire.
module uart_tx_sched #(
  parameter int NREQ       = 4,
  parameter int BIT_CLK    = 8,
  parameter int FRAME_BITS = 10,
  parameter int GAP_CLKS   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              cts,
  output logic [7:0]        txdata,
  output logic              tx_strobe,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [15:0]       sent_count
);

  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLK;
  localparam int MAX_CLKS   = (FRAME_CLKS > GAP_CLKS) ? FRAME_CLKS : GAP_CLKS;
  localparam int CW         = $clog2(MAX_CLKS + 1);
  localparam int PW         = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic [PW:0]   sum;
  logic          found;
  logic          take;

  // Pick the first valid requester at or after rr_ptr, wrapping upward.
  // Invalid requesters are skipped within the same cycle.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Reset overrides the handshake so nothing is accepted in a reset cycle;
  // cts only matters while idle, a frame in flight always completes.
  always_comb begin
    take      = (state == IDLE) && cts && found && !rst;
    req_ready = '0;
    if (take) req_ready[win] = 1'b1;
  end

  // Scheduler FSM: accept in IDLE, time the frame in SEND, optional GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      txdata     <= 8'h00;
      tx_strobe  <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 3'd0;
      sent_count <= 16'h0000;
    end else begin
      tx_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            txdata     <= req_data[{win, 3'b000} +: 8];
            tx_strobe  <= 1'b1;
            grant_id   <= 3'(win);
            rr_ptr     <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
            sent_count <= sent_count + 16'd1;
            cnt        <= CW'(FRAME_CLKS - 1);
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (cnt == '0) begin
            if (GAP_CLKS == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
              cnt   <= CW'(GAP_CLKS - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
